// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM encoding, sizes.
package muldiv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned OP_W     = 3;
   localparam int unsigned CNT_W    = 6;
   localparam int unsigned ITER_CNT = 32;

   // funct3 encodings of the M-extension ops
   localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
   localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
   localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
   localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
   localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
   localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
   localparam logic [OP_W-1:0] OP_REM    = 3'b110;
   localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_if.sv
// ID-EX to mul/div unit request/response bundle.
interface muldiv_if #(
   parameter int unsigned WIDTH = muldiv_pkg::XLEN
);
   import muldiv_pkg::*;

   logic              Start;
   logic              ClearE;
   logic [OP_W-1:0]   MulDivOpE;
   logic [WIDTH-1:0]  SrcAE;
   logic [WIDTH-1:0]  SrcBE;
   logic              Busy;
   logic              Done;
   logic [WIDTH-1:0]  Result;

   // pipeline side: issues operations, observes status
   modport master (
      output Start, ClearE, MulDivOpE, SrcAE, SrcBE,
      input  Busy, Done, Result
   );

   // execution unit side
   modport slave (
      input  Start, ClearE, MulDivOpE, SrcAE, SrcBE,
      output Busy, Done, Result
   );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; with neg tied to the sign bit it yields |val|.
module muldiv_signfix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res_c
);

   // negate when requested, otherwise pass through
   assign res_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on a shared 64-bit register.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   localparam int unsigned     AW        = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_CNT - 1);
   localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              neg_q, neg_d;
   logic              via_q, via_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  result_q, result_d;

   logic              a_signed, b_signed, sign_a, sign_b, res_neg;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic              div_zero, div_ovf;
   logic [WIDTH-1:0]  special_res;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    part_rem;
   logic              rem_ge;
   logic [WIDTH-1:0]  rem_next;
   logic [AW-1:0]     fix_in, fix_out;
   logic [WIDTH-1:0]  fix_sel;

   // operand sign handling for the incoming request
   assign a_signed = (bus.MulDivOpE == OP_MULH) || (bus.MulDivOpE == OP_MULHSU) ||
                     (bus.MulDivOpE == OP_DIV)  || (bus.MulDivOpE == OP_REM);
   assign b_signed = (bus.MulDivOpE == OP_MULH) || (bus.MulDivOpE == OP_DIV) ||
                     (bus.MulDivOpE == OP_REM);
   assign sign_a   = a_signed && bus.SrcAE[WIDTH-1];
   assign sign_b   = b_signed && bus.SrcBE[WIDTH-1];

   // result sign: quotient/product take sign(A)^sign(B), remainder and MULHSU take sign(A)
   always_comb begin
      res_neg = 1'b0;
      case (bus.MulDivOpE)
         OP_MULH, OP_DIV:                    res_neg = sign_a ^ sign_b;
         OP_MULHSU, OP_REM:                  res_neg = sign_a;
         OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: res_neg = 1'b0;
         default:                            res_neg = 1'b0;
      endcase
   end

   muldiv_signfix #(.W(WIDTH)) u_abs_a (.val(bus.SrcAE), .neg(sign_a), .res_c(mag_a));
   muldiv_signfix #(.W(WIDTH)) u_abs_b (.val(bus.SrcBE), .neg(sign_b), .res_c(mag_b));

   // divide special cases resolved without iterating
   assign div_zero    = bus.MulDivOpE[2] && (bus.SrcBE == '0);
   assign div_ovf     = ((bus.MulDivOpE == OP_DIV) || (bus.MulDivOpE == OP_REM)) &&
                        (bus.SrcAE == MIN_INT) && (bus.SrcBE == '1);
   assign special_res = div_zero ? (bus.MulDivOpE[1] ? bus.SrcAE : '1)
                                 : (bus.MulDivOpE[1] ? '0 : MIN_INT);

   // one multiply step: add multiplicand into the high half when the low bit is set, shift right
   assign mul_sum = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

   // one restoring divide step on the 33-bit shifted partial remainder
   assign part_rem = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_ge   = part_rem >= {1'b0, b_q};
   assign rem_next = rem_ge ? WIDTH'(part_rem - {1'b0, b_q}) : part_rem[WIDTH-1:0];

   // sign fix: divide results are widened so one 64-bit negator serves every op
   assign fix_in  = op_q[2] ? {{WIDTH{1'b0}}, (op_q[1] ? acc_q[AW-1:WIDTH] : acc_q[WIDTH-1:0])}
                            : acc_q;
   muldiv_signfix #(.W(AW)) u_fix (.val(fix_in), .neg(neg_q), .res_c(fix_out));
   assign fix_sel = (op_q[2] || (op_q == OP_MUL)) ? fix_out[WIDTH-1:0] : fix_out[AW-1:WIDTH];

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      b_d      = b_q;
      neg_d    = neg_q;
      via_d    = via_q;
      done_d   = 1'b0;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               op_d  = bus.MulDivOpE;
               neg_d = res_neg;
               if (div_zero || div_ovf) begin
                  state_d  = ST_DONE;
                  via_d    = 1'b0;
                  done_d   = 1'b1;
                  result_d = special_res;
               end else begin
                  state_d = ST_CALC;
                  via_d   = 1'b1;
                  cnt_d   = '0;
                  b_d     = mag_b;
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
               end
            end
         end
         ST_CALC: begin
            acc_d = op_q[2] ? {rem_next, acc_q[WIDTH-2:0], rem_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FIX: begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = fix_sel;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            via_d   = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      // flush overrides everything, including a coincident Start
      if (bus.ClearE) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         via_d    = 1'b0;
         done_d   = 1'b0;
         result_d = '0;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         via_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         via_q    <= via_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.Busy   = (state_q == ST_CALC) || (state_q == ST_FIX) ||
                       ((state_q == ST_DONE) && via_q);
   assign bus.Done   = done_q;
   assign bus.Result = result_q;

endmodule
